// File: rtl/inv_perm_pkg.sv
// Shared constants, FSM state type and bit-index helper for the inverse lane permutation.
package inv_perm_pkg;

    localparam int LINE_W = 25;
    localparam int LINES  = 64;
    localparam int CNT_W  = $clog2(LINES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Flat bit position of lane (x, y) inside a 5x5 line.
    function automatic int idx(input int x, input int y);
        return x + 5 * y;
    endfunction

endpackage

// File: rtl/inv_permutation_func_swap.sv
// Combinational inverse pi mapping: out[x][y] = in[y][(2x+3y) mod 5].
module inv_swap
    import inv_perm_pkg::*;
(
    input  logic [LINE_W-1:0] i_line,
    output logic [LINE_W-1:0] o_line
);

    for (genvar gx = 0; gx < 5; gx++) begin : g_x
        for (genvar gy = 0; gy < 5; gy++) begin : g_y
            assign o_line[idx(gx, gy)] = i_line[idx(gy, (2 * gx + 3 * gy) % 5)];
        end
    end

endmodule

// File: rtl/inv_permutation_func.sv
// Streams a 64-line block through the inverse lane permutation with a one-stage output register.
// Optional block checksum output o_out_chk is enabled by defining INV_PERM_CHK_EN.
module inv_permutation_func
    import inv_perm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [LINE_W-1:0] i_in_line,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [LINE_W-1:0] o_out_line,
    output logic [CNT_W-1:0]  o_out_idx,
    output logic              o_busy,
    output logic              o_done
`ifdef INV_PERM_CHK_EN
    ,output logic [LINE_W-1:0] o_out_chk
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W:0]    r_in_cnt;
    logic              r_out_valid;
    logic [LINE_W-1:0] r_out_line;
    logic [CNT_W-1:0]  r_out_idx;
    logic [LINE_W-1:0] w_swapped;
    logic              w_in_acc;
    logic              w_out_acc;
    logic              w_arm;

    inv_swap u_swap (
        .i_line (i_in_line),
        .o_line (w_swapped)
    );

    assign o_in_ready = (r_state == RUN) && (!r_out_valid || i_out_ready);
    assign w_in_acc   = i_in_valid && o_in_ready;
    assign w_out_acc  = r_out_valid && i_out_ready;
    assign w_arm      = (r_state == IDLE) && i_start;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = RUN;
            RUN:     if (w_in_acc && (r_in_cnt == (CNT_W+1)'(LINES - 1))) w_state_nxt = DRAIN;
            DRAIN:   if (w_out_acc && (r_out_idx == CNT_W'(LINES - 1))) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_in_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_line  <= '0;
            r_out_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arm) begin
                r_in_cnt    <= '0;
                r_out_idx   <= '0;
                r_out_valid <= 1'b0;
            end else if (w_in_acc) begin
                // A simultaneous output accept simply gets overwritten by the new line.
                r_out_line  <= w_swapped;
                r_out_idx   <= r_in_cnt[CNT_W-1:0];
                r_out_valid <= 1'b1;
                r_in_cnt    <= r_in_cnt + (CNT_W+1)'(1);
            end else if (w_out_acc) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef INV_PERM_CHK_EN
    logic [LINE_W-1:0] r_chk;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_arm) begin
            r_chk <= '0;
        end else if (w_in_acc) begin
            r_chk <= r_chk ^ w_swapped;
        end
    end

    assign o_out_chk = r_chk;
`endif

    assign o_out_valid = r_out_valid;
    assign o_out_line  = r_out_line;
    assign o_out_idx   = r_out_idx;
    assign o_busy      = (r_state == RUN) || (r_state == DRAIN);
    assign o_done      = (r_state == DONE);

endmodule

// File: tb/tb_inv_permutation_func.sv
// Self-checking bench for inv_permutation_func against a lane-coordinate reference model.
module tb_inv_permutation_func;
    import inv_perm_pkg::*;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic [LINE_W-1:0] i_in_line = '0;
    logic              o_out_valid;
    logic              i_out_ready = 1'b0;
    logic [LINE_W-1:0] o_out_line;
    logic [CNT_W-1:0]  o_out_idx;
    logic              o_busy;
    logic              o_done;
`ifdef INV_PERM_CHK_EN
    logic [LINE_W-1:0] o_out_chk;
`endif

    always #5 clk = ~clk;

    inv_permutation_func dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_line   (i_in_line),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_line  (o_out_line),
        .o_out_idx   (o_out_idx),
        .o_busy      (o_busy),
        .o_done      (o_done)
`ifdef INV_PERM_CHK_EN
        ,.o_out_chk  (o_out_chk)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [LINE_W-1:0] blk  [LINES];
    logic [LINE_W-1:0] orig [LINES];
    logic [LINE_W-1:0] got  [LINES];
    int done_cyc;

    // Inverse map in lane coordinates: out[x][y] = in[y][(2x+3y) mod 5].
    function automatic logic [LINE_W-1:0] inv_model(input logic [LINE_W-1:0] a);
        logic [LINE_W-1:0] r;
        r = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x + 5 * y] = a[y + 5 * ((2 * x + 3 * y) % 5)];
        return r;
    endfunction

    // Encoder's forward map: A'[x,y] = A[(x+3y) mod 5, x].
    function automatic logic [LINE_W-1:0] fwd_model(input logic [LINE_W-1:0] a);
        logic [LINE_W-1:0] r;
        r = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x + 5 * y] = a[((x + 3 * y) % 5) + 5 * x];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds blk[] as one block; outputs are compared with inv_model(blk[n]) in order.
    task automatic run_block(input int stall_at, input int stall_len, input int abort_at,
                             input bit rnd, output int cyc_done);
        int sent = 0;
        int rcvd = 0;
        int cyc = 0;
        int stalled = 0;
        int last_out = -10;
        bit fin = 0;
        bit in_stall;
        logic [LINE_W-1:0] exp_chk = '0;
        cyc_done = -1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
        while (!fin && cyc < 3000) begin
            i_in_valid = (sent < LINES) && (!rnd || ($urandom_range(0, 3) != 0));
            i_in_line  = (sent < LINES) ? blk[sent] : '0;
            i_start    = rnd && ($urandom_range(0, 7) == 0);
            in_stall   = 1'b0;
            if (stall_at >= 0 && o_out_valid && o_out_idx == CNT_W'(stall_at) && stalled < stall_len) begin
                i_out_ready = 1'b0;
                in_stall = 1'b1;
                stalled++;
            end else begin
                i_out_ready = !rnd || ($urandom_range(0, 2) != 0);
            end
            #1;
            if (in_stall) begin
                chk("stall_in_ready", 32'(o_in_ready), 32'd0);
                chk("stall_out_line", 32'(o_out_line), 32'(inv_model(blk[stall_at])));
            end
            if (o_out_valid && i_out_ready) begin
                if (rcvd < LINES) begin
                    chk("out_line", 32'(o_out_line), 32'(inv_model(blk[rcvd])));
                    chk("out_idx", 32'(o_out_idx), rcvd);
                    got[rcvd] = o_out_line;
                    last_out = cyc;
                end else begin
                    checks++;
                    errors++;
                    $error("FAIL extra_output observed=%0d expected=%0d", rcvd + 1, LINES);
                end
                rcvd++;
            end
            if (i_in_valid && o_in_ready) begin
                exp_chk ^= inv_model(blk[sent]);
                sent++;
            end
            if (o_done) begin
                chk("done_all_out", rcvd, LINES);
                chk("done_latency", cyc - last_out, 32'd1);
`ifdef INV_PERM_CHK_EN
                chk("checksum", 32'(o_out_chk), 32'(exp_chk));
`endif
                cyc_done = cyc;
                fin = 1;
            end
            tick();
            cyc++;
            if (abort_at >= 0 && sent == abort_at + 1) fin = 1;
        end
        i_start    = 1'b0;
        i_in_valid = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $error("FAIL timeout observed=%0d expected=%0d", rcvd, LINES);
        end else if (abort_at < 0) begin
            chk("done_width", 32'(o_done), 32'd0);
            chk("idle_busy", 32'(o_busy), 32'd0);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_out_line", 32'(o_out_line), 32'd0);
        chk("rst_out_idx", 32'(o_out_idx), 32'd0);
        chk("rst_in_ready", 32'(o_in_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        i_rst = 1'b0;
        i_out_ready = 1'b1;
        tick();

        // Input valid in IDLE must not be taken.
        i_in_valid = 1'b1;
        i_in_line  = 25'h1ABCDE;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("idle_in_ready", 32'(o_in_ready), 32'd0);
            tick();
            chk("idle_out_valid", 32'(o_out_valid), 32'd0);
        end
        i_in_valid = 1'b0;

        // Full block, continuous flow.
        for (int i = 0; i < LINES; i++) blk[i] = LINE_W'(i * 32'h12345);
        run_block(-1, 0, -1, 1'b0, done_cyc);
        chk("stream_cycles", done_cyc, 32'd65);

        // Single-bit lanes.
        for (int i = 0; i < LINES; i++) blk[i] = LINE_W'($urandom);
        blk[0] = 25'h1 << 1;
        blk[1] = 25'h1;
        blk[2] = 25'h1 << 24;
        run_block(-1, 0, -1, 1'b0, done_cyc);
        chk("map_bit1", 32'(got[0]), 32'h40);
        chk("map_bit0", 32'(got[1]), 32'h1);
        chk("map_bit24", 32'(got[2]), 32'h200000);

        // Round trip through the encoder's forward map, random flow control.
        for (int i = 0; i < LINES; i++) begin
            orig[i] = LINE_W'($urandom);
            blk[i]  = fwd_model(orig[i]);
        end
        run_block(-1, 0, -1, 1'b1, done_cyc);
        for (int i = 0; i < LINES; i++) chk("round_trip", 32'(got[i]), 32'(orig[i]));

        // Backpressure at line 10.
        for (int i = 0; i < LINES; i++) blk[i] = LINE_W'($urandom);
        run_block(10, 5, -1, 1'b0, done_cyc);
        chk("stall_cycles", done_cyc, 32'd70);

        // Reset in the middle of a block.
        for (int i = 0; i < LINES; i++) blk[i] = LINE_W'($urandom);
        run_block(-1, 0, 30, 1'b0, done_cyc);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst_out_valid", 32'(o_out_valid), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_out_idx", 32'(o_out_idx), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("midrst_no_done", 32'(o_done), 32'd0);
            tick();
        end
        run_block(-1, 0, -1, 1'b0, done_cyc);
        chk("after_rst_cycles", done_cyc, 32'd65);

`ifdef INV_PERM_CHK_EN
        for (int i = 0; i < LINES; i++) blk[i] = '1;
        run_block(-1, 0, -1, 1'b0, done_cyc);
        chk("chk_all_ones", 32'(o_out_chk), 32'd0);
        for (int i = 0; i < LINES; i++) blk[i] = '0;
        blk[LINES-1] = 25'h1 << 1;
        run_block(-1, 0, -1, 1'b0, done_cyc);
        chk("chk_single", 32'(o_out_chk), 32'h40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
